// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_pkg
//  Description : Shared pipeline constants and types. This covers the IF/ID
//                bubble encoding and the instruction-fetch state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam int INST_W = 32;

    // IF/ID flush value, also used for every bubble the fetch stage emits
    localparam logic [INST_W-1:0] BUBBLE_INST = 32'h0000_0001;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    // Sequential PC increment; wraps modulo 2^32 by construction
    function automatic logic [INST_W-1:0] pc_plus4(input logic [INST_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Owns the PC and drives a
//                variable-latency req/ready instruction memory. It presents
//                each instruction with its PC+4 to IF/ID, honours hazard
//                stalls and ID-stage branch redirects, and squashes
//                wrong-path fetches.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] adrIF,
    output logic [31:0] inst_IF,
    output logic        IF_ID_write,
    output logic        IF_Flush
);

    fetch_state_t       state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        hold_inst_q, hold_inst_d;
    // Address of a request that is still outstanding after a redirect. The
    // bus has no cancel, so the old address must stay on imem_addr while
    // the PC already points at the branch target.
    logic [31:0]        drop_addr_q, drop_addr_d;
    logic [31:0]        pc_inc;

    logic               req_c;
    logic [31:0]        addr_c;
    logic [31:0]        inst_c;
    logic               write_c;
    logic               flush_c;

    assign pc_inc = pc_plus4(pc_q);

    // Next-state and output decode from registered state and current inputs
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_inst_d = hold_inst_q;
        drop_addr_d = drop_addr_q;
        req_c       = 1'b0;
        addr_c      = pc_q;
        inst_c      = BUBBLE_INST;
        write_c     = 1'b0;
        flush_c     = 1'b0;

        case (state_q)
            FETCH: begin
                req_c = 1'b1;
                if (branch_taken) begin
                    write_c = 1'b1;
                    flush_c = 1'b1;
                    pc_d    = branch_target;
                    if (!imem_ready) begin
                        // Request still in flight: drain it before refetching
                        drop_addr_d = pc_q;
                        state_d     = DROP;
                    end
                end else if (imem_ready) begin
                    if (pc_write) begin
                        inst_c  = imem_rdata;
                        write_c = 1'b1;
                        pc_d    = pc_inc;
                    end else begin
                        // Stalled: park the instruction until IF/ID can take it
                        hold_inst_d = imem_rdata;
                        state_d     = HOLD;
                    end
                end else begin
                    // Waiting on memory: feed bubbles so IF/ID never re-latches
                    write_c = pc_write;
                end
            end

            HOLD: begin
                if (branch_taken) begin
                    write_c     = 1'b1;
                    flush_c     = 1'b1;
                    pc_d        = branch_target;
                    hold_inst_d = BUBBLE_INST;
                    state_d     = FETCH;
                end else if (pc_write) begin
                    inst_c  = hold_inst_q;
                    write_c = 1'b1;
                    pc_d    = pc_inc;
                    state_d = FETCH;
                end
            end

            DROP: begin
                req_c  = 1'b1;
                addr_c = drop_addr_q;
                if (branch_taken) begin
                    write_c = 1'b1;
                    flush_c = 1'b1;
                    pc_d    = branch_target;
                end else begin
                    write_c = pc_write;
                end
                if (imem_ready) begin
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Output stage: reset forces every IF/ID-facing signal to its idle value
    always_comb begin
        imem_req    = rst_n & req_c;
        imem_addr   = addr_c;
        inst_IF     = inst_c;
        adrIF       = pc_inc;
        IF_ID_write = rst_n & write_c;
        IF_Flush    = rst_n & flush_c;
        if (!rst_n) begin
            inst_IF = BUBBLE_INST;
        end
    end

    // Program counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Fetch state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Hold buffer for an instruction accepted during a stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_inst_q <= BUBBLE_INST;
        end else begin
            hold_inst_q <= hold_inst_d;
        end
    end

    // Address of the request being drained after a redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_addr_q <= RESET_PC;
        end else begin
            drop_addr_q <= drop_addr_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. It uses cycle vectors
//                with expected outputs, applied through a scoreboard queue,
//                plus a hand-written asynchronous reset sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        pc_write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] adrIF;
    logic [31:0] inst_IF;
    logic        IF_ID_write;
    logic        IF_Flush;

    int compared   = 0;
    int mismatched = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_write     (pc_write),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .adrIF        (adrIF),
        .inst_IF      (inst_IF),
        .IF_ID_write  (IF_ID_write),
        .IF_Flush     (IF_Flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rn;
        logic        pw;
        logic        bt;
        logic [31:0] tgt;
        logic        rdy;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        ci;     // check inst_IF
        logic [31:0] inst;
        logic        ca;     // check adrIF
        logic [31:0] adr;
        logic        wr;
        logic        fl;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(
        input logic rn, input logic pw, input logic bt, input logic [31:0] tgt,
        input logic rdy, input logic [31:0] rdata,
        input logic req, input logic [31:0] addr,
        input logic ci, input logic [31:0] inst,
        input logic ca, input logic [31:0] adr,
        input logic wr, input logic fl);
        vec_t v;
        v.rn = rn; v.pw = pw; v.bt = bt; v.tgt = tgt; v.rdy = rdy; v.rdata = rdata;
        v.req = req; v.addr = addr; v.ci = ci; v.inst = inst; v.ca = ca; v.adr = adr;
        v.wr = wr; v.fl = fl;
        return v;
    endfunction

    task automatic chk(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL step %0d %s: got %h expected %h", step, name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n         = v.rn;
        pc_write      = v.pw;
        branch_taken  = v.bt;
        branch_target = v.tgt;
        imem_ready    = v.rdy;
        imem_rdata    = v.rdata;
        sb.push_back(v);
    endtask

    task automatic check_out(input int step);
        vec_t e;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL step %0d scoreboard: got empty expected entry", step);
            return;
        end
        e = sb.pop_front();
        chk("imem_req",    step, {31'd0, imem_req},    {31'd0, e.req});
        chk("imem_addr",   step, imem_addr,            e.addr);
        chk("IF_ID_write", step, {31'd0, IF_ID_write}, {31'd0, e.wr});
        chk("IF_Flush",    step, {31'd0, IF_Flush},    {31'd0, e.fl});
        if (e.ci) chk("inst_IF", step, inst_IF, e.inst);
        if (e.ca) chk("adrIF",   step, adrIF,   e.adr);
    endtask

    localparam logic [31:0] B = 32'h0000_0001;

    initial begin
        rst_n = 1'b0; pc_write = 1'b0; branch_taken = 1'b0;
        branch_target = 32'd0; imem_ready = 1'b0; imem_rdata = 32'd0;

        //             rn pw bt tgt            rdy rdata           req addr           ci inst           ca adr            wr fl
        // Reset held, then zero-wait streaming
        tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'hAAAA_0000, 0, 32'h0,        1, B,             1, 32'h4,        0, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'hA000_0000, 1, 32'h0,        1, 32'hA000_0000, 1, 32'h4,        1, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'hA000_0001, 1, 32'h4,        1, 32'hA000_0001, 1, 32'h8,        1, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'hA000_0002, 1, 32'h8,        1, 32'hA000_0002, 1, 32'hC,        1, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'hA000_0003, 1, 32'hC,        1, 32'hA000_0003, 1, 32'h10,       1, 0));
        // 2-wait fetch at 0x10
        tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,         1, 32'h10,       1, B,             0, 32'h0,        1, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,         1, 32'h10,       1, B,             0, 32'h0,        1, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'hB000_0000, 1, 32'h10,       1, 32'hB000_0000, 1, 32'h14,       1, 0));
        // Stall with ready: HOLD for three cycles, then release
        tbl.push_back(mk(1, 0, 0, 32'h0,        1, 32'hDEAD_BEEF, 1, 32'h14,       0, B,             0, 32'h0,        0, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,         0, 32'h14,       0, B,             0, 32'h0,        0, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,         0, 32'h14,       0, B,             0, 32'h0,        0, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,         0, 32'h14,       1, 32'hDEAD_BEEF, 1, 32'h18,       1, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'hC000_0000, 1, 32'h18,       1, 32'hC000_0000, 1, 32'h1C,       1, 0));
        // Branch to 0x100 during a 3-wait fetch at 0x1C: drain then refetch
        tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,         1, 32'h1C,       1, B,             0, 32'h0,        1, 0));
        tbl.push_back(mk(1, 1, 1, 32'h100,      0, 32'h0,         1, 32'h1C,       1, B,             0, 32'h0,        1, 1));
        tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,         1, 32'h1C,       1, B,             0, 32'h0,        1, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'hDEAD_0000, 1, 32'h1C,       1, B,             0, 32'h0,        1, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'hD000_0000, 1, 32'h100,      1, 32'hD000_0000, 1, 32'h104,      1, 0));
        // Branch while in HOLD: held instruction lost
        tbl.push_back(mk(1, 0, 0, 32'h0,        1, 32'hE000_0000, 1, 32'h104,      0, B,             0, 32'h0,        0, 0));
        tbl.push_back(mk(1, 0, 1, 32'h200,      0, 32'h0,         0, 32'h104,      1, B,             0, 32'h0,        1, 1));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'hF000_0000, 1, 32'h200,      1, 32'hF000_0000, 1, 32'h204,      1, 0));
        // Branch with ready overrides pc_write=0; response discarded
        tbl.push_back(mk(1, 0, 1, 32'h300,      1, 32'hBAD0_0000, 1, 32'h204,      1, B,             0, 32'h0,        1, 1));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'h0000_0011, 1, 32'h300,      1, 32'h0000_0011, 1, 32'h304,      1, 0));
        // PC wrap at the top of the address space
        tbl.push_back(mk(1, 1, 1, 32'hFFFF_FFFC, 1, 32'h0,       1, 32'h304,      1, B,             0, 32'h0,        1, 1));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'h0000_0022, 1, 32'hFFFF_FFFC, 1, 32'h0000_0022, 1, 32'h0,        1, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'h0000_0033, 1, 32'h0,        1, 32'h0000_0033, 1, 32'h4,        1, 0));
        // Stall while waiting, then branch into DROP and re-branch inside DROP
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,         1, 32'h4,        0, B,             0, 32'h0,        0, 0));
        tbl.push_back(mk(1, 0, 1, 32'h40,       0, 32'h0,         1, 32'h4,        1, B,             0, 32'h0,        1, 1));
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,         1, 32'h4,        1, B,             0, 32'h0,        0, 0));
        tbl.push_back(mk(1, 0, 1, 32'h80,       0, 32'h0,         1, 32'h4,        1, B,             0, 32'h0,        1, 1));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'h0000_0099, 1, 32'h4,        1, B,             0, 32'h0,        1, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'h0000_0044, 1, 32'h80,       1, 32'h0000_0044, 1, 32'h84,       1, 0));
        // Reset asserted between edges while a fetch waits
        tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,         1, 32'h84,       1, B,             0, 32'h0,        1, 0));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,         0, 32'h0,        1, B,             1, 32'h4,        0, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'h0000_0055, 1, 32'h0,        1, 32'h0000_0055, 1, 32'h4,        1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #4;
            check_out(i);
        end

        // Enter HOLD, then pull reset mid-cycle with no clock edge
        @(negedge clk);
        drive(mk(1, 0, 0, 32'h0, 1, 32'h0000_0077, 1, 32'h4, 0, B, 0, 32'h0, 0, 0));
        #4;
        check_out(100);
        @(negedge clk);
        drive(mk(1, 1, 0, 32'h0, 0, 32'h0, 0, 32'h4, 1, 32'h0000_0077, 1, 32'h8, 1, 0));
        #1;
        check_out(101);
        sb.push_back(mk(0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, B, 1, 32'h4, 0, 0));
        rst_n = 1'b0;
        #1;
        check_out(102);
        @(negedge clk);
        drive(mk(1, 1, 0, 32'h0, 1, 32'h0000_0066, 1, 32'h0, 1, 32'h0000_0066, 1, 32'h4, 1, 0));
        #4;
        check_out(103);
        @(negedge clk);
        drive(mk(1, 1, 0, 32'h0, 1, 32'h0000_0067, 1, 32'h4, 1, 32'h0000_0067, 1, 32'h8, 1, 0));
        #4;
        check_out(104);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
